lfsr_seq_checker: RTL

Downstream consumer of the `lfsr_counter` output stream. It samples the LFSR value on each valid cycle, predicts the next value from the configured feedback taps, and acquires lock after a run of correct predictions. Once locked, it counts sequence errors and detects a stuck all-zero state. It sits directly after the counter and gives the bench and system status logic a self-checking view of generator health.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_predictor.sv | 50 +++++
 rtl/lfsr_seq_checker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_pkg
// Brief   : Shared LFSR constants, checker state encoding and next-value
//           helper used by lfsr_counter and lfsr_seq_checker.
// Rev     : 1.0  initial release
// ============================================================================
package lfsr_pkg;

  // Default generator geometry: 4-bit maximal-length LFSR, taps on bits 3 and 2
  localparam int          LFSR_DEF_WIDTH = 4;
  localparam logic [15:0] LFSR_DEF_TAPS  = 16'h000C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Next LFSR value for any width up to 16. Callers zero-extend q and taps
  // and truncate the result back to their own width; the zero-extended upper
  // bits contribute nothing to the parity, so the low bits are exact.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q,
                                            input logic [15:0] taps);
    lfsr_next = {q[14:0], ^(q & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_predictor.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_predictor
// Brief   : Holds the predicted next LFSR sample. 'load' seeds the prediction
//           from an incoming sample, 'advance' steps the current prediction.
// Rev     : 1.0  initial release
// ============================================================================
module lfsr_predictor
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_DEF_TAPS[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pred
);

  logic [WIDTH-1:0] pred_q;
  logic [WIDTH-1:0] pred_d;

  // Select the next prediction: clear, reseed from the sample, or step
  always_comb begin
    pred_d = pred_q;
    if (clr) begin
      pred_d = '0;
    end else if (load) begin
      pred_d = WIDTH'(lfsr_next(16'(din), 16'(TAPS)));
    end else if (advance) begin
      pred_d = WIDTH'(lfsr_next(16'(pred_q), 16'(TAPS)));
    end
  end

  // Prediction register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_q <= '0;
    end else begin
      pred_q <= pred_d;
    end
  end

  assign pred = pred_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_seq_checker
// Brief   : Tracks an LFSR sample stream, locks after LOCK_CNT correct
//           predictions, counts locked mispredictions and flags all-zero
//           samples. Define LFSR_CHK_PERIOD_EN to add the 'period' output,
//           the measured sequence length while locked.
// Rev     : 1.0  initial release
// ============================================================================
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = LFSR_DEF_TAPS[WIDTH-1:0],
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] lfsr_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic             stuck_zero
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic [WIDTH:0]   period
`endif
);

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [3:0] c_loss_cnt = 4'(LOSS_CNT);

  chk_state_t  state_q, state_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [3:0]  xcnt_q, xcnt_d;
  logic        locked_q, locked_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_count_q, err_count_d;
  logic        stuck_q, stuck_d;

  logic [WIDTH-1:0] w_pred;
  logic             w_pred_load;
  logic             w_pred_adv;
  logic             w_match;
  logic             w_zero;
  logic [3:0]       w_mcnt_inc;
  logic [3:0]       w_xcnt_inc;
  logic [15:0]      w_err_inc;

  assign w_match    = (lfsr_in == w_pred);
  assign w_zero     = (lfsr_in == '0);
  assign w_mcnt_inc = mcnt_q + 4'd1;
  assign w_xcnt_inc = xcnt_q + 4'd1;
  assign w_err_inc  = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  lfsr_predictor #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .load    (w_pred_load),
    .advance (w_pred_adv),
    .din     (lfsr_in),
    .pred    (w_pred)
  );

  // Next-state, counters and status for each accepted sample
  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    xcnt_d      = xcnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    stuck_d     = stuck_q;
    w_pred_load = 1'b0;
    w_pred_adv  = 1'b0;

    if (clr) begin
      // Clear discards any sample presented in the same cycle
      state_d     = SEARCH;
      mcnt_d      = '0;
      xcnt_d      = '0;
      err_count_d = '0;
      stuck_d     = 1'b0;
    end else if (in_valid) begin
      if (w_zero) begin
        // An all-zero LFSR never leaves zero: restart acquisition
        stuck_d     = 1'b1;
        state_d     = SEARCH;
        mcnt_d      = '0;
        xcnt_d      = '0;
        w_pred_load = 1'b1;
        if (state_q == LOCKED) begin
          err_pulse_d = 1'b1;
          err_count_d = w_err_inc;
        end
      end else begin
        case (state_q)
          SEARCH: begin
            w_pred_load = 1'b1;
            mcnt_d      = '0;
            xcnt_d      = '0;
            state_d     = VERIFY;
          end
          VERIFY: begin
            if (w_match) begin
              w_pred_adv = 1'b1;
              mcnt_d     = w_mcnt_inc;
              if (w_mcnt_inc == c_lock_cnt) begin
                state_d = LOCKED;
                mcnt_d  = '0;
                xcnt_d  = '0;
              end
            end else begin
              w_pred_load = 1'b1;
              mcnt_d      = '0;
            end
          end
          LOCKED: begin
            // Always resync to the sample so a single slip costs one error
            w_pred_load = 1'b1;
            if (w_match) begin
              xcnt_d = '0;
            end else begin
              err_pulse_d = 1'b1;
              err_count_d = w_err_inc;
              xcnt_d      = w_xcnt_inc;
              if (w_xcnt_inc == c_loss_cnt) begin
                state_d = SEARCH;
                mcnt_d  = '0;
                xcnt_d  = '0;
              end
            end
          end
          default: begin
            state_d = SEARCH;
            mcnt_d  = '0;
            xcnt_d  = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      mcnt_q      <= '0;
      xcnt_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      xcnt_q      <= xcnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      stuck_q     <= stuck_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign stuck_zero = stuck_q;

`ifdef LFSR_CHK_PERIOD_EN
  logic [WIDTH:0]   pcnt_q, pcnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [WIDTH:0]   w_pcnt_inc;

  assign w_pcnt_inc = pcnt_q + 1'b1;

  // Count valid samples between recurrences of the value that achieved lock
  always_comb begin
    pcnt_d   = pcnt_q;
    period_d = period_q;
    entry_d  = entry_q;
    if (clr) begin
      pcnt_d   = '0;
      period_d = '0;
      entry_d  = '0;
    end else if (in_valid) begin
      if (state_q != LOCKED && state_d == LOCKED) begin
        entry_d = lfsr_in;
        pcnt_d  = '0;
      end else if (state_q == LOCKED) begin
        if (lfsr_in == entry_q) begin
          period_d = w_pcnt_inc;
          pcnt_d   = '0;
        end else begin
          pcnt_d = w_pcnt_inc;
        end
      end
    end
  end

  // Period measurement registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q   <= '0;
      period_q <= '0;
      entry_q  <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      entry_q  <= entry_d;
    end
  end

  assign period = period_q;
`endif

endmodule
`default_nettype wire
